// File: rtl/dds_phase_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_gen_if
// Description : Bus bundle for the DDS phase accumulator. Carries the run
//               enable, the FTW valid/ready load channel and the phase index
//               output stream with its strobes.
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_phase_gen_if #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 9
);
  logic               enable;
  logic [ACC_W-1:0]   ftw_data;
  logic               ftw_valid;
  logic               ftw_ready;
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic               wrap;

  // Controller side: owns the enable and the FTW load channel.
  modport master (
    output enable, ftw_data, ftw_valid,
    input  ftw_ready, phase, phase_valid, wrap
  );

  // Accumulator side: consumes the load channel, produces the phase stream.
  modport slave (
    input  enable, ftw_data, ftw_valid,
    output ftw_ready, phase, phase_valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_gen
// Description : Programmable DDS phase accumulator feeding the quarter-wave
//               sine LUT. Produces a PHASE_W-bit phase index that advances by
//               the active frequency tuning word every DIV clocks. New tuning
//               words are taken over a valid/ready handshake and only become
//               active at a phase wrap so the output never glitches mid-cycle.
//               Optional macro PHASE_DITHER_EN adds LFSR dither to the
//               truncated phase index.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_phase_gen #(
  parameter int               ACC_W       = 24,
  parameter int               PHASE_W     = 9,
  parameter int               DIV         = 1,
  parameter logic [ACC_W-1:0] DEFAULT_FTW = ACC_W'(24'h8000)
) (
  input wire logic       clk,
  input wire logic       rst_n,
  dds_phase_gen_if.slave bus
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [ACC_W-1:0]   ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]   ftw_pend_q, ftw_pend_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;

  logic               running_w;
  logic               tick_w;
  logic               ftw_ready_w;
  logic               accept_w;
  logic [ACC_W:0]     sum_w;
  logic               carry_w;
  logic [PHASE_W-1:0] phase_next_w;

  // A word is outstanding exactly while PENDING, so ready is a decode of the
  // registered state and therefore glitch-free.
  assign running_w   = (state_q == S_RUN) || (state_q == S_PENDING);
  assign tick_w      = running_w && bus.enable && (div_cnt_q == DIV_LAST);
  assign ftw_ready_w = (state_q != S_PENDING);
  assign accept_w    = bus.ftw_valid && ftw_ready_w;
  assign sum_w       = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign carry_w     = sum_w[ACC_W];

`ifdef PHASE_DITHER_EN
  localparam int               DITH_W    = ACC_W - PHASE_W;
  localparam logic [ACC_W-1:0] DITH_MASK = (ACC_W'(1) << DITH_W) - ACC_W'(1);

  logic [15:0]       lfsr_q, lfsr_d;
  logic [ACC_W+15:0] lfsr_ext_w;
  logic [ACC_W-1:0]  dither_w;
  logic [ACC_W-1:0]  dith_sum_w;

  // Dither only perturbs the truncated index; the carry of this add is
  // dropped and wrap detection stays on the undithered accumulator.
  assign lfsr_ext_w   = {{ACC_W{1'b0}}, lfsr_q};
  assign dither_w     = lfsr_ext_w[ACC_W-1:0] & DITH_MASK;
  assign dith_sum_w   = sum_w[ACC_W-1:0] + dither_w;
  assign phase_next_w = dith_sum_w[ACC_W-1 -: PHASE_W];

  // Galois LFSR (taps 16,14,13,11) stepping once per sample tick.
  always_comb begin
    lfsr_d = lfsr_q;
    if (tick_w) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // LFSR register, restarts from its seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign phase_next_w = sum_w[ACC_W-1 -: PHASE_W];
`endif

  // Next-state and datapath: tick handling, FTW load/commit, enable control.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    div_cnt_d     = div_cnt_q;
    ftw_act_d     = ftw_act_q;
    ftw_pend_d    = ftw_pend_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        acc_d     = '0;
        div_cnt_d = '0;
        phase_d   = '0;
        // Nothing is sounding, so a new word can take effect at once.
        if (accept_w) begin
          ftw_act_d = bus.ftw_data;
        end
        if (bus.enable) begin
          state_d = S_RUN;
        end
      end

      S_RUN, S_PENDING: begin
        if (!bus.enable) begin
          acc_d     = '0;
          div_cnt_d = '0;
          phase_d   = '0;
          state_d   = S_IDLE;
          if (state_q == S_PENDING) begin
            ftw_act_d = ftw_pend_q;
          end
          if (accept_w) begin
            ftw_act_d = bus.ftw_data;
          end
        end else begin
          if (tick_w) begin
            acc_d         = sum_w[ACC_W-1:0];
            div_cnt_d     = '0;
            phase_d       = phase_next_w;
            phase_valid_d = 1'b1;
            wrap_d        = carry_w;
            // The wrapping step itself still uses the old word. A zero word
            // can never wrap, so it yields on the next tick instead.
            if ((state_q == S_PENDING) && (carry_w || (ftw_act_q == '0))) begin
              ftw_act_d = ftw_pend_q;
              state_d   = S_RUN;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
          // Only reachable from RUN; a word taken on a carry tick waits for
          // the following wrap.
          if (accept_w) begin
            ftw_pend_d = bus.ftw_data;
            state_d    = S_PENDING;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      div_cnt_q     <= '0;
      ftw_act_q     <= DEFAULT_FTW;
      ftw_pend_q    <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      div_cnt_q     <= div_cnt_d;
      ftw_act_q     <= ftw_act_d;
      ftw_pend_q    <= ftw_pend_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign bus.ftw_ready   = ftw_ready_w;
  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.wrap        = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_phase_gen
// Description : Bench for dds_phase_gen. Two instances (DIV=1 and DIV=4) run
//               directed scenarios followed by randomized enable/FTW traffic,
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_phase_gen;

  localparam int ACC_W   = 24;
  localparam int PHASE_W = 9;
  localparam longint MOD = 64'd16777216;

  logic clk;
  logic rst_n;
  logic en0, v0, en1, v1;
  logic [ACC_W-1:0] d0, d1;
  int n_checks = 0;
  int n_errors = 0;

  dds_phase_gen_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) bus0 ();
  dds_phase_gen_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) bus1 ();

  assign bus0.enable = en0;  assign bus0.ftw_valid = v0;  assign bus0.ftw_data = d0;
  assign bus1.enable = en1;  assign bus1.ftw_valid = v1;  assign bus1.ftw_data = d1;

  dds_phase_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DIV(1), .DEFAULT_FTW(24'h8000))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dds_phase_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DIV(4), .DEFAULT_FTW(24'h8000))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural view: a running/idle flag, an accumulator value, the active
  // word and at most one word waiting for the next wrap.
  typedef struct packed {
    logic [23:0] acc;
    logic [7:0]  cnt;
    logic [23:0] act;
    logic [23:0] fpend;
    logic        pend;
    logic        run;
    logic [8:0]  phase;
    logic        pv;
    logic        wrap;
  } mstate_t;

  function automatic mstate_t reset_m();
    mstate_t r;
    r = '0;
    r.act = 24'h8000;
    return r;
  endfunction

  function automatic mstate_t step(mstate_t m, int div, logic en, logic v, logic [23:0] d);
    mstate_t n;
    longint  total;
    logic    fire;
    n     = m;
    fire  = v && !m.pend;
    n.pv  = 1'b0;
    n.wrap = 1'b0;
    if (!m.run || !en) begin
      n.acc = '0; n.cnt = '0; n.phase = '0;
      if (m.pend) begin n.act = m.fpend; n.pend = 1'b0; end
      if (fire) n.act = d;
      n.run = !m.run && en;
    end else begin
      if (int'(m.cnt) == div - 1) begin
        total   = longint'(m.acc) + longint'(m.act);
        n.wrap  = (total >= MOD);
        n.acc   = 24'(total % MOD);
        n.phase = 9'(n.acc / 24'h8000);
        n.pv    = 1'b1;
        n.cnt   = '0;
        if (m.pend && (n.wrap || m.act == 24'd0)) begin n.act = m.fpend; n.pend = 1'b0; end
      end else begin
        n.cnt = m.cnt + 8'd1;
      end
      if (fire) begin n.fpend = d; n.pend = 1'b1; end
    end
    return n;
  endfunction

  mstate_t m0, m1;

  // Model update on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= reset_m();
      m1 <= reset_m();
    end else begin
      m0 <= step(m0, 1, en0, v0, d0);
      m1 <= step(m1, 4, en1, v1, d1);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    check("m0_phase", 32'(bus0.phase), 32'(m0.phase));
    check("m0_pv",    32'(bus0.phase_valid), 32'(m0.pv));
    check("m0_wrap",  32'(bus0.wrap), 32'(m0.wrap));
    check("m0_ready", 32'(bus0.ftw_ready), 32'(!m0.pend));
    check("m1_phase", 32'(bus1.phase), 32'(m1.phase));
    check("m1_pv",    32'(bus1.phase_valid), 32'(m1.pv));
    check("m1_wrap",  32'(bus1.wrap), 32'(m1.wrap));
    check("m1_ready", 32'(bus1.ftw_ready), 32'(!m1.pend));
  end

  // Wait for a DUT0 strobe, optionally with a given phase, within a bound.
  task automatic wait0(input string name, input int want_phase, input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus0.phase_valid && (want_phase < 0 || int'(bus0.phase) == want_phase)) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic load0(input logic [23:0] w);
    v0 = 1'b1; d0 = w;
    @(negedge clk);
    v0 = 1'b0;
  endtask

  function automatic logic [23:0] pick_ftw();
    case ($urandom_range(0, 7))
      0: return 24'h008000;
      1: return 24'h010000;
      2: return 24'h020000;
      3: return 24'h000000;
      4: return 24'h800000;
      5: return 24'hFFFFFF;
      6: return 24'($urandom);
      default: return 24'($urandom) & 24'h0FFFFF;
    endcase
  endfunction

  // One negedge worth of random stimulus; a word is held until accepted.
  task automatic rand_drive(inout logic en, inout logic v, inout logic [23:0] d,
                            inout logic rdy_prev, input logic rdy_now);
    if (!(v && !rdy_prev)) begin
      v = ($urandom_range(0, 3) == 0);
      d = pick_ftw();
    end
    if (en) begin
      if ($urandom_range(0, 399) == 0) en = 1'b0;
    end else begin
      if ($urandom_range(0, 7) == 0) en = 1'b1;
    end
    rdy_prev = rdy_now;
  endtask

  logic rp0, rp1;
  bit   seen;

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0; v0 = 1'b0; d0 = '0;
    en1 = 1'b0; v1 = 1'b0; d1 = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_phase0", 32'(bus0.phase), 32'd0);
    check("rst_pv0",    32'(bus0.phase_valid), 32'd0);
    check("rst_wrap0",  32'(bus0.wrap), 32'd0);
    check("rst_ready0", 32'(bus0.ftw_ready), 32'd1);
    check("rst_phase1", 32'(bus1.phase), 32'd0);
    check("rst_ready1", 32'(bus1.ftw_ready), 32'd1);

    // Default FTW: one index step per clock, wrap only on 511->0.
    rst_n = 1'b1;
    en0   = 1'b1;
    wait0("t1_first_step", -1, 10);
    check("t1_phase1", 32'(bus0.phase), 32'd1);
    check("t1_nowrap", 32'(bus0.wrap), 32'd0);
    repeat (510) @(negedge clk);
    check("t1_phase511", 32'(bus0.phase), 32'd511);
    check("t1_wrap511",  32'(bus0.wrap), 32'd0);
    @(negedge clk);
    check("t1_phase_wrap", 32'(bus0.phase), 32'd0);
    check("t1_wrap",       32'(bus0.wrap), 32'd1);
    repeat (512) @(negedge clk);
    check("t1_period_phase", 32'(bus0.phase), 32'd0);
    check("t1_period_wrap",  32'(bus0.wrap), 32'd1);

    // DIV=4: strobe every fourth clock; disable clears phase.
    en1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.phase_valid) begin seen = 1'b1; break; end
    end
    check("t5_first_pv", 32'(seen), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t5_pv_cadence", 32'(bus1.phase_valid), 32'(k == 4));
    end
    check("t5_phase2", 32'(bus1.phase), 32'd2);
    en1 = 1'b0;
    @(negedge clk);
    check("t5_dis_phase", 32'(bus1.phase), 32'd0);
    check("t5_dis_pv",    32'(bus1.phase_valid), 32'd0);

    // FTW 0x10000 loaded while idle: steps of 2, wrap every 256 ticks.
    en0 = 1'b0;
    @(negedge clk);
    check("t2_idle_phase", 32'(bus0.phase), 32'd0);
    load0(24'h010000);
    en0 = 1'b1;
    wait0("t2_first_step", -1, 10);
    check("t2_phase2", 32'(bus0.phase), 32'd2);
    repeat (255) @(negedge clk);
    check("t2_wrap_phase", 32'(bus0.phase), 32'd0);
    check("t2_wrap",       32'(bus0.wrap), 32'd1);

    // Mid-period load waits for the wrap, then takes effect.
    en0 = 1'b0;
    @(negedge clk);
    load0(24'h008000);
    en0 = 1'b1;
    wait0("t3_reach100", 100, 200);
    load0(24'h020000);
    check("t3_ready_low", 32'(bus0.ftw_ready), 32'd0);
    check("t3_old_step",  32'(bus0.phase), 32'd101);
    wait0("t3_wrap_seen", 0, 600);
    check("t3_wrap",        32'(bus0.wrap), 32'd1);
    check("t3_ready_back",  32'(bus0.ftw_ready), 32'd1);
    @(negedge clk);
    check("t3_new_step", 32'(bus0.phase), 32'd4);

    // Load accepted on the carry tick waits a whole further period.
    wait0("t4_reach508", 508, 200);
    load0(24'h008000);
    check("t4_wrap",       32'(bus0.wrap), 32'd1);
    check("t4_ready_low",  32'(bus0.ftw_ready), 32'd0);
    repeat (127) @(negedge clk);
    check("t4_still_old",  32'(bus0.phase), 32'd508);
    @(negedge clk);
    check("t4_commit_wrap", 32'(bus0.wrap), 32'd1);
    check("t4_ready_back",  32'(bus0.ftw_ready), 32'd1);
    @(negedge clk);
    check("t4_new_step", 32'(bus0.phase), 32'd1);

    // Asynchronous reset while a word is pending.
    load0(24'h020000);
    check("t6_pending", 32'(bus0.ftw_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_phase", 32'(bus0.phase), 32'd0);
    check("t6_pv",    32'(bus0.phase_valid), 32'd0);
    check("t6_wrap",  32'(bus0.wrap), 32'd0);
    check("t6_ready", 32'(bus0.ftw_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wait0("t6_restart", -1, 10);
    check("t6_default_ftw", 32'(bus0.phase), 32'd1);
    en0 = 1'b0;

    // Randomized traffic on both instances.
    rp0 = 1'b1; rp1 = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      rand_drive(en0, v0, d0, rp0, bus0.ftw_ready);
      rand_drive(en1, v1, d1, rp1, bus1.ftw_ready);
      if ($urandom_range(0, 3999) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rnd_rst_ready", 32'(bus0.ftw_ready), 32'd1);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
